alu_result_buffer: RTL and testbench

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_result_buffer.sv | 111 +++++++++++
 tb/tb_alu_result_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// First-word fall-through result buffer between the ALU and its consumer.
// Stores ALU results in order, throttles issue via ALU_HOLD, flags dropped words.
module alu_result_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int HOLD_MARGIN = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    EX_ALU,
    input  logic                     EX_ALU_VLD,
    output logic [DATA_WIDTH-1:0]    OUT_DATA,
    output logic                     OUT_VLD,
    input  logic                     OUT_RDY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic                     ALU_HOLD,
    output logic                     OVERFLOW,
    input  logic                     CLR_OVF
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] MARGIN_C = (AW + 1)'(HOLD_MARGIN);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  hold_q, hold_d;
    logic                  ovf_q, ovf_d;
    logic                  empty_w, full_w;
    logic                  push, pop, drop;
    logic [AW:0]           free_d;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_C);

    // Output side is a valid/ready handshake: a word transfers on any edge where
    // OUT_VLD and OUT_RDY are both high; OUT_DATA/OUT_VLD hold while stalled.
    // The ALU side has no backpressure: a valid word arriving when full with no
    // pop that cycle is dropped and recorded in OVERFLOW.
    assign pop  = !empty_w && OUT_RDY;
    assign push = EX_ALU_VLD && (!full_w || pop);
    assign drop = EX_ALU_VLD && full_w && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Hold is computed from the post-edge occupancy so it is registered, not combinational.
    always_comb begin
        free_d = DEPTH_C - count_d;
        hold_d = (free_d <= MARGIN_C);
    end

    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; occupancy tracking alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= EX_ALU;
        end
    end

    assign OUT_DATA = RST ? mem_q[rd_ptr_q] : '0;
    assign OUT_VLD  = !empty_w;
    assign COUNT    = count_q;
    assign FULL     = full_w;
    assign EMPTY    = empty_w;
    assign ALU_HOLD = hold_q;
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer (DATA_WIDTH=8, DEPTH=8, HOLD_MARGIN=2).
module tb_alu_result_buffer;

    logic       CLK;
    logic       RST;
    logic [7:0] EX_ALU;
    logic       EX_ALU_VLD;
    logic [7:0] OUT_DATA;
    logic       OUT_VLD;
    logic       OUT_RDY;
    logic [3:0] COUNT;
    logic       FULL;
    logic       EMPTY;
    logic       ALU_HOLD;
    logic       OVERFLOW;
    logic       CLR_OVF;

    int n_total;
    int n_pass;

    alu_result_buffer #(
        .DATA_WIDTH (8),
        .DEPTH      (8),
        .HOLD_MARGIN(2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EX_ALU    (EX_ALU),
        .EX_ALU_VLD(EX_ALU_VLD),
        .OUT_DATA  (OUT_DATA),
        .OUT_VLD   (OUT_VLD),
        .OUT_RDY   (OUT_RDY),
        .COUNT     (COUNT),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .ALU_HOLD  (ALU_HOLD),
        .OVERFLOW  (OVERFLOW),
        .CLR_OVF   (CLR_OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        EX_ALU     = d;
        EX_ALU_VLD = 1'b1;
        tick();
        EX_ALU_VLD = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d);
        check({tag, "_vld"}, 32'(OUT_VLD), 32'd1);
        check({tag, "_data"}, 32'(OUT_DATA), 32'(d));
        OUT_RDY = 1'b1;
        tick();
        OUT_RDY = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 32'(COUNT), 32'd0);
        check({tag, "_empty"}, 32'(EMPTY), 32'd1);
        check({tag, "_full"}, 32'(FULL), 32'd0);
        check({tag, "_vld"}, 32'(OUT_VLD), 32'd0);
        check({tag, "_hold"}, 32'(ALU_HOLD), 32'd0);
        check({tag, "_ovf"}, 32'(OVERFLOW), 32'd0);
        check({tag, "_data"}, 32'(OUT_DATA), 32'd0);
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        RST        = 1'b0;
        EX_ALU     = 8'h00;
        EX_ALU_VLD = 1'b0;
        OUT_RDY    = 1'b0;
        CLR_OVF    = 1'b0;

        // Reset, with a push attempt that must be ignored.
        #1;
        check_reset_outputs("rst");
        EX_ALU     = 8'hE7;
        EX_ALU_VLD = 1'b1;
        tick();
        check("rst_ignore_count", 32'(COUNT), 32'd0);
        EX_ALU_VLD = 1'b0;
        RST        = 1'b1;
        tick();

        // Idle pop attempt on empty buffer changes nothing.
        OUT_RDY = 1'b1;
        tick();
        OUT_RDY = 1'b0;
        check("idle_count", 32'(COUNT), 32'd0);
        check("idle_empty", 32'(EMPTY), 32'd1);

        // Three pushes, then in-order drain; first word visible right after its edge.
        push_word(8'h11);
        check("lat_vld", 32'(OUT_VLD), 32'd1);
        check("lat_data", 32'(OUT_DATA), 32'h11);
        push_word(8'h22);
        push_word(8'h33);
        check("p3_count", 32'(COUNT), 32'd3);
        check("p3_head", 32'(OUT_DATA), 32'h11);
        tick();
        check("stall_data", 32'(OUT_DATA), 32'h11);
        check("stall_vld", 32'(OUT_VLD), 32'd1);
        pop_expect("d3_0", 8'h11);
        pop_expect("d3_1", 8'h22);
        pop_expect("d3_2", 8'h33);
        check("d3_empty", 32'(EMPTY), 32'd1);
        check("d3_vld", 32'(OUT_VLD), 32'd0);

        // Hold threshold: free=3 -> 0, free=2 -> 1, back to free=3 -> 0.
        for (int i = 1; i <= 5; i++) push_word(8'(i));
        check("hold_5", 32'(ALU_HOLD), 32'd0);
        push_word(8'h06);
        check("hold_6", 32'(ALU_HOLD), 32'd1);
        check("hold_6_count", 32'(COUNT), 32'd6);
        pop_expect("hold_pop", 8'h01);
        check("hold_5b", 32'(ALU_HOLD), 32'd0);
        check("hold_5b_count", 32'(COUNT), 32'd5);

        // Fill to 8 (entries 0x02..0x09) and overflow with 0xAA.
        push_word(8'h07);
        push_word(8'h08);
        push_word(8'h09);
        check("fill_full", 32'(FULL), 32'd1);
        check("fill_count", 32'(COUNT), 32'd8);
        check("fill_hold", 32'(ALU_HOLD), 32'd1);
        check("fill_ovf", 32'(OVERFLOW), 32'd0);
        push_word(8'hAA);
        check("drop_ovf", 32'(OVERFLOW), 32'd1);
        check("drop_count", 32'(COUNT), 32'd8);
        check("drop_head", 32'(OUT_DATA), 32'h02);
        tick();
        check("ovf_sticky", 32'(OVERFLOW), 32'd1);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        check("clr_ovf", 32'(OVERFLOW), 32'd0);

        // Drop and clear in the same cycle: set wins.
        CLR_OVF = 1'b1;
        push_word(8'hAB);
        CLR_OVF = 1'b0;
        check("set_wins_ovf", 32'(OVERFLOW), 32'd1);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        check("clr_ovf2", 32'(OVERFLOW), 32'd0);

        // Full with a simultaneous pop: 0xBB accepted, goes to the tail.
        check("bb_head", 32'(OUT_DATA), 32'h02);
        EX_ALU     = 8'hBB;
        EX_ALU_VLD = 1'b1;
        OUT_RDY    = 1'b1;
        tick();
        EX_ALU_VLD = 1'b0;
        OUT_RDY    = 1'b0;
        check("bb_count", 32'(COUNT), 32'd8);
        check("bb_ovf", 32'(OVERFLOW), 32'd0);
        pop_expect("bb_d0", 8'h03);
        pop_expect("bb_d1", 8'h04);
        pop_expect("bb_d2", 8'h05);
        pop_expect("bb_d3", 8'h06);
        pop_expect("bb_d4", 8'h07);
        pop_expect("bb_d5", 8'h08);
        pop_expect("bb_d6", 8'h09);
        pop_expect("bb_d7", 8'hBB);
        check("bb_empty", 32'(EMPTY), 32'd1);
        check("bb_hold", 32'(ALU_HOLD), 32'd0);

        // Streaming push+pop across pointer wrap, occupancy constant at 1.
        push_word(8'h00);
        for (int i = 1; i < 20; i++) begin
            check($sformatf("stream_%0d", i), 32'(OUT_DATA), 32'(i - 1));
            EX_ALU     = 8'(i);
            EX_ALU_VLD = 1'b1;
            OUT_RDY    = 1'b1;
            tick();
            check($sformatf("stream_cnt_%0d", i), 32'(COUNT), 32'd1);
        end
        EX_ALU_VLD = 1'b0;
        OUT_RDY    = 1'b0;
        pop_expect("stream_last", 8'h13);
        check("stream_empty", 32'(EMPTY), 32'd1);

        // Mid-operation asynchronous reset, then first push becomes the head.
        push_word(8'hC1);
        push_word(8'hC2);
        push_word(8'hC3);
        push_word(8'hC4);
        check("pre_rst_count", 32'(COUNT), 32'd4);
        #2;
        RST = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        EX_ALU     = 8'h77;
        EX_ALU_VLD = 1'b1;
        tick();
        check("in_rst_count", 32'(COUNT), 32'd0);
        EX_ALU_VLD = 1'b0;
        RST        = 1'b1;
        push_word(8'h5A);
        check("post_rst_data", 32'(OUT_DATA), 32'h5A);
        check("post_rst_count", 32'(COUNT), 32'd1);
        check("post_rst_vld", 32'(OUT_VLD), 32'd1);
        pop_expect("post_rst_pop", 8'h5A);
        check("post_rst_empty", 32'(EMPTY), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
